uart_port: RTL and testbench

- Serial-side responder for the CPU's UART handshake.
- Accepts `start`/`t_data` from the MEM stage and serializes one 8N1 byte on `txd`, reporting `busy`.
- Deserializes `rxd` into a one-entry holding register, reporting `ready`/`r_data` until the CPU pulses `clear`.
- Sits at the top level between the core's `ext_uart_*` nets and the board UART pins.

---
 rtl/uart_port_if.sv | 25 ++
 rtl/uart_port.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_uart_port.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_port_if.sv
// CPU-side handshake bundle of uart_port: transmit request/data/busy and
// receive ready/data/clear plus the sticky framing-error flag.
interface uart_port_if #(
    parameter int WORD = 32
);
    logic            uart_start;
    logic [WORD-1:0] uart_t_data;
    logic            uart_busy;
    logic            uart_clear;
    logic            uart_ready;
    logic [WORD-1:0] uart_r_data;
    logic            frame_err;

    // CPU / MEM-stage side
    modport master (
        output uart_start, uart_t_data, uart_clear,
        input  uart_busy, uart_ready, uart_r_data, frame_err
    );

    // UART port side
    modport slave (
        input  uart_start, uart_t_data, uart_clear,
        output uart_busy, uart_ready, uart_r_data, frame_err
    );
endinterface

// File: rtl/uart_port.sv
// uart_port: 8N1 UART responder. Serializes one byte per uart_start on txd,
// deserializes rxd into a one-entry holding register with ready/clear, and
// keeps a sticky framing-error flag.
// Optional feature macro: UART_PARITY_EN adds an even-parity bit to both
// directions (11-bit frame); a receive parity mismatch discards the byte.
module uart_port #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int WORD     = 32
) (
    input  logic       clk,
    input  logic       rst,
    uart_port_if.slave cpu,
    output logic       txd,
    input  logic       rxd
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    // Mid-bit sampling needs at least a few clocks per bit.
    if (DIV < 4) begin : g_div_check
        $error("uart_port: CLK_FREQ/BAUD must be >= 4");
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
`else
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          tx_bit_end;

    // Only the low byte of the transmit bus is serialized.
    logic unused_t_data_hi;
    assign unused_t_data_hi = ^cpu.uart_t_data[WORD-1:8];

    // TX next state: the divider restarts at 0 on every state entry, so each
    // state lasts exactly DIV clocks; a start held through STOP chains frames.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_idx_d   = tx_idx_q;
        tx_byte_d  = tx_byte_q;
        tx_bit_end = (tx_cnt_q == DIV_M1);
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (cpu.uart_start) begin
                    tx_byte_d  = cpu.uart_t_data[7:0];
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PAR;
`else
                        tx_state_d = TX_STOP;
`endif
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PAR: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (cpu.uart_start) begin
                        tx_byte_d  = cpu.uart_t_data[7:0];
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // txd and busy are registered from the next state so the pin is glitch-free
    // and changes on the same edge as the state.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (tx_state_d != TX_IDLE);
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_byte_d[tx_idx_d];
`ifdef UART_PARITY_EN
            TX_PAR:   txd_d = ^tx_byte_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // TX state register; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_byte_q  <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_byte_q  <= tx_byte_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign txd           = txd_q;
    assign cpu.uart_busy = busy_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_IDLE} rx_state_t;
`else
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;
`endif

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_load, rx_err, rx_bit_end;
`ifdef UART_PARITY_EN
    logic          par_ok_q, par_ok_d;
`endif
    logic          ready_q, ready_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          ferr_q, ferr_d;

    // Two-flop synchronizer for the asynchronous serial input; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rxd};
    end

    assign rx_s = sync_q[1];

    // RX next state: confirm the start bit at half a bit, then sample each
    // following bit every DIV clocks so samples land mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_load    = 1'b0;
        rx_err     = 1'b0;
        rx_bit_end = (rx_cnt_q == DIV_M1);
`ifdef UART_PARITY_EN
        par_ok_d   = par_ok_q;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d = '0;
                    if (!rx_s) begin
                        rx_idx_d   = '0;
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;   // glitch, not a start bit
                    end
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PAR;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PAR: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    par_ok_d   = (rx_s == ^rx_shift_q);
                    rx_state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_d = '0;
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;
`ifdef UART_PARITY_EN
                        rx_load = par_ok_q;
                        rx_err  = !par_ok_q;
`else
                        rx_load = 1'b1;
`endif
                    end else begin
                        rx_err     = 1'b1;
                        rx_state_d = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                rx_cnt_d = '0;
                if (rx_s) rx_state_d = RX_IDLE;
            end
            default: begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Holding register: clear drops ready/err, but a same-cycle load or new
    // error wins; an overrun simply overwrites the data.
    always_comb begin
        ready_d = ready_q;
        rdata_d = rdata_q;
        ferr_d  = ferr_q;
        if (cpu.uart_clear) begin
            ready_d = 1'b0;
            ferr_d  = 1'b0;
        end
        if (rx_load) begin
            ready_d = 1'b1;
            rdata_d = rx_shift_q;
        end
        if (rx_err) ferr_d = 1'b1;
    end

    // RX state and holding register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
`ifdef UART_PARITY_EN
            par_ok_q   <= 1'b0;
`endif
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
`ifdef UART_PARITY_EN
            par_ok_q   <= par_ok_d;
`endif
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            ferr_q     <= ferr_d;
        end
    end

    assign cpu.uart_ready  = ready_q;
    assign cpu.uart_r_data = {{(WORD-8){1'b0}}, rdata_q};
    assign cpu.frame_err   = ferr_q;

endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port with DIV=16: TX framing, loopback, glitch,
// framing error, busy/ignore, overrun, clear/load race and mid-frame reset.
module tb_uart_port;
    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int DIV      = 16;
    localparam int WORD     = 32;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd_drv = 1'b1;
    logic loop_en = 1'b0;
    logic txd, rxd;

    uart_port_if #(.WORD(WORD)) cpu ();

    assign rxd = loop_en ? txd : rxd_drv;

    uart_port #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WORD(WORD)) dut (
        .clk (clk),
        .rst (rst),
        .cpu (cpu),
        .txd (txd),
        .rxd (rxd)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic       exp_bits[$];
    logic [7:0] exp_rx[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line levels of one frame, LSB first.
    task automatic push_frame(input logic [7:0] b);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef UART_PARITY_EN
        exp_bits.push_back(^b);
`endif
        exp_bits.push_back(1'b1);
    endtask

    // Called at the first negedge after the start edge; every clock of each
    // bit must show the expected level, busy must last exactly NBITS*DIV.
    task automatic tx_capture(input string tag, input int inj_k);
        int   busy_n;
        logic e, ok;
        busy_n = 0;
        for (int b = 0; b < NBITS; b++) begin
            e  = exp_bits.pop_front();
            ok = 1'b1;
            for (int c = 0; c < DIV; c++) begin
                if (b * DIV + c == inj_k) begin
                    cpu.uart_t_data = 32'h0000_0011;
                    cpu.uart_start  = 1'b1;
                end else if (b * DIV + c == inj_k + 1) begin
                    cpu.uart_start = 1'b0;
                end
                if (txd !== e) ok = 1'b0;
                if (cpu.uart_busy) busy_n++;
                @(negedge clk);
            end
            check($sformatf("%s bit%0d", tag, b), {31'b0, ok}, 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            if (cpu.uart_busy) busy_n++;
            @(negedge clk);
        end
        check({tag, " busy clocks"}, busy_n, NBITS * DIV);
    endtask

    task automatic tx_send(input string tag, input logic [31:0] d, input int inj_k);
        push_frame(d[7:0]);
        @(negedge clk);
        cpu.uart_t_data = d;
        cpu.uart_start  = 1'b1;
        @(negedge clk);
        cpu.uart_start  = 1'b0;
        tx_capture(tag, inj_k);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop, input logic bad_par);
        logic [NBITS-1:0] bits;
`ifdef UART_PARITY_EN
        bits = {stop, (^b) ^ bad_par, b, 1'b0};
`else
        bits = {stop, b, 1'b0};
        if (bad_par) bits[0] = 1'b0;
`endif
        for (int i = 0; i < NBITS; i++) begin
            @(negedge clk);
            rxd_drv = bits[i];
            repeat (DIV - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd_drv = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * DIV && !seen; i++) begin
            if (cpu.uart_ready) seen = 1'b1;
            else @(negedge clk);
        end
        check(tag, {31'b0, seen}, 32'd1);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        cpu.uart_clear = 1'b1;
        @(negedge clk);
        cpu.uart_clear = 1'b0;
    endtask

    // Holds clear high until ready is seen, so clear is asserted on the load edge.
    task automatic clear_watch(output bit seen);
        seen = 1'b0;
        cpu.uart_clear = 1'b1;
        for (int i = 0; i < 12 * DIV && !seen; i++) begin
            @(negedge clk);
            if (cpu.uart_ready) seen = 1'b1;
        end
        cpu.uart_clear = 1'b0;
    endtask

    initial begin
        logic [7:0] e;
        bit         seen, ok;
        cpu.uart_start  = 1'b0;
        cpu.uart_t_data = '0;
        cpu.uart_clear  = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst txd",    {31'b0, txd}, 32'd1);
        check("rst busy",   {31'b0, cpu.uart_busy}, 32'd0);
        check("rst ready",  {31'b0, cpu.uart_ready}, 32'd0);
        check("rst r_data", cpu.uart_r_data, 32'd0);
        check("rst ferr",   {31'b0, cpu.frame_err}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // TX frame, upper bits ignored
        tx_send("tx55", 32'h0000_0A55, -1);

        // loopback
        loop_en = 1'b1;
        exp_rx.push_back(8'hA3);
        tx_send("lbA3", 32'h0000_00A3, -1);
        wait_ready("lb ready");
        e = exp_rx.pop_front();
        check("lb r_data", cpu.uart_r_data, {24'b0, e});
        loop_en = 1'b0;
        clear_pulse();
        check("lb clear ready", {31'b0, cpu.uart_ready}, 32'd0);
        check("lb clear r_data", cpu.uart_r_data, {24'b0, e});

        // glitch shorter than half a bit
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check("glitch ready", {31'b0, cpu.uart_ready}, 32'd0);
        check("glitch ferr",  {31'b0, cpu.frame_err}, 32'd0);

        // framing error
        rx_send(8'h3C, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("ferr set",   {31'b0, cpu.frame_err}, 32'd1);
        check("ferr ready", {31'b0, cpu.uart_ready}, 32'd0);
        clear_pulse();
        check("ferr clear", {31'b0, cpu.frame_err}, 32'd0);

        // start while busy is ignored
        tx_send("busy22", 32'h0000_0022, 40);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (txd !== 1'b1 || cpu.uart_busy !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        check("busy no requeue", {31'b0, ok}, 32'd1);

        // overrun
        exp_rx.push_back(8'h01);
        rx_send(8'h01, 1'b1, 1'b0);
        wait_ready("ovr ready1");
        e = exp_rx.pop_front();
        check("ovr data1", cpu.uart_r_data, {24'b0, e});
        exp_rx.push_back(8'h02);
        rx_send(8'h02, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        e = exp_rx.pop_front();
        check("ovr data2", cpu.uart_r_data, {24'b0, e});
        check("ovr ready2", {31'b0, cpu.uart_ready}, 32'd1);

        // clear coincident with load
        clear_pulse();
        check("race pre ready", {31'b0, cpu.uart_ready}, 32'd0);
        exp_rx.push_back(8'h02);
        fork
            rx_send(8'h02, 1'b1, 1'b0);
            clear_watch(seen);
        join
        @(negedge clk);
        e = exp_rx.pop_front();
        check("race seen",  {31'b0, seen}, 32'd1);
        check("race ready", {31'b0, cpu.uart_ready}, 32'd1);
        check("race data",  cpu.uart_r_data, {24'b0, e});

        // reset in the middle of a frame
        @(negedge clk);
        cpu.uart_t_data = 32'h0;
        cpu.uart_start  = 1'b1;
        @(negedge clk);
        cpu.uart_start  = 1'b0;
        repeat (70) @(negedge clk);
        check("mid txd pre",  {31'b0, txd}, 32'd0);
        check("mid busy pre", {31'b0, cpu.uart_busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid rst txd",  {31'b0, txd}, 32'd1);
        check("mid rst busy", {31'b0, cpu.uart_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tx_send("post5A", 32'h0000_005A, -1);

`ifdef UART_PARITY_EN
        tx_send("par07", 32'h0000_0007, -1);
        clear_pulse();
        rx_send(8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("par ferr",  {31'b0, cpu.frame_err}, 32'd1);
        check("par ready", {31'b0, cpu.uart_ready}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
